mem_bus_master: RTL and testbench

Bus master that sits directly upstream of the 8-bit shared-bus memory. It turns CPU instruction-fetch, load and store requests into the memory's cycle protocol on the shared `memReqBus` / `memWriteReq` lines. That protocol is a combinational read by address, and a two-phase write: data first, then address. The block assembles 16-bit little-endian instructions from two byte reads and returns load data, each with a one-cycle completion pulse.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/mem_bus_master_if.sv | 23 ++
 rtl/mem_bus_master.sv | 130 +++++++++++++
 tb/tb_mem_bus_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared state encoding and widths for the memory bus master.
// CPU-side benches decode the FSM state with these constants.
package mem_bus_pkg;

   localparam int INSTR_WIDTH = 16;
   localparam int BYTE_W      = INSTR_WIDTH / 2;
   localparam int STATE_W     = 3;

   localparam logic [STATE_W-1:0] ENC_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ENC_FETCH_LO = 3'd1;
   localparam logic [STATE_W-1:0] ENC_FETCH_HI = 3'd2;
   localparam logic [STATE_W-1:0] ENC_LOAD     = 3'd3;
   localparam logic [STATE_W-1:0] ENC_ST_DATA  = 3'd4;
   localparam logic [STATE_W-1:0] ENC_ST_ADDR  = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = ENC_IDLE,
      S_FETCH_LO = ENC_FETCH_LO,
      S_FETCH_HI = ENC_FETCH_HI,
      S_LOAD     = ENC_LOAD,
      S_ST_DATA  = ENC_ST_DATA,
      S_ST_ADDR  = ENC_ST_ADDR
   } state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Shared memory bus: address/data lines, write strobe, read data.
interface mem_bus_master_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8
);

   logic [ADDR_WIDTH-1:0] memReqBus;
   logic                  memWriteReq;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output memReqBus,
      output memWriteReq,
      input  read_data
   );

   modport slave (
      input  memReqBus,
      input  memWriteReq,
      output read_data
   );

endinterface

// File: rtl/mem_bus_master.sv
// Fetch/load/store bus master for the 8-bit shared-bus memory.
// Optional MEM_BUS_ALIGN_CHECK_EN rejects odd fetch addresses.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_req,
   input  logic [ADDR_WIDTH-1:0]  fetch_pc,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   input  logic                   ld_req,
   input  logic                   st_req,
   input  logic [ADDR_WIDTH-1:0]  ls_addr,
   input  logic [DATA_WIDTH-1:0]  st_data,
   output logic [DATA_WIDTH-1:0]  ld_data,
   output logic                   ls_done,
   output logic                   align_err,
   output logic                   busy,
   mem_bus_master_if.master       mem
);

   state_e                   state_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic [INSTR_WIDTH-1:0]   instr_q;
   logic [DATA_WIDTH-1:0]    ld_data_q;
   logic                     instr_valid_q;
   logic                     ls_done_q;
`ifdef MEM_BUS_ALIGN_CHECK_EN
   logic                     align_err_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         instr_q       <= '0;
         ld_data_q     <= '0;
         instr_valid_q <= 1'b0;
         ls_done_q     <= 1'b0;
`ifdef MEM_BUS_ALIGN_CHECK_EN
         align_err_q   <= 1'b0;
`endif
      end else begin
         instr_valid_q <= 1'b0;
         ls_done_q     <= 1'b0;
`ifdef MEM_BUS_ALIGN_CHECK_EN
         align_err_q   <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (st_req) begin
                  state_q <= S_ST_DATA;
                  addr_q  <= ls_addr;
                  data_q  <= st_data;
               end else if (ld_req) begin
                  state_q <= S_LOAD;
                  addr_q  <= ls_addr;
               end else if (fetch_req) begin
`ifdef MEM_BUS_ALIGN_CHECK_EN
                  if (fetch_pc[0]) begin
                     align_err_q <= 1'b1;
                  end else begin
                     state_q <= S_FETCH_LO;
                     addr_q  <= fetch_pc;
                  end
`else
                  state_q <= S_FETCH_LO;
                  addr_q  <= fetch_pc;
`endif
               end
            end
            S_FETCH_LO: begin
               instr_q[BYTE_W-1:0] <= BYTE_W'(mem.read_data);
               state_q             <= S_FETCH_HI;
            end
            S_FETCH_HI: begin
               instr_q[INSTR_WIDTH-1:BYTE_W] <= BYTE_W'(mem.read_data);
               instr_valid_q                 <= 1'b1;
               state_q                       <= S_IDLE;
            end
            S_LOAD: begin
               ld_data_q <= mem.read_data;
               ls_done_q <= 1'b1;
               state_q   <= S_IDLE;
            end
            S_ST_DATA: state_q <= S_ST_ADDR;
            S_ST_ADDR: begin
               ls_done_q <= 1'b1;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Bus is a pure function of state so reset drops it to 0 at once.
   always_comb begin
      mem.memReqBus   = '0;
      mem.memWriteReq = 1'b0;
      unique case (state_q)
         S_FETCH_LO: mem.memReqBus = addr_q;
         S_FETCH_HI: mem.memReqBus = addr_q + ADDR_WIDTH'(1);
         S_LOAD:     mem.memReqBus = addr_q;
         S_ST_DATA: begin
            mem.memReqBus   = ADDR_WIDTH'(data_q);
            mem.memWriteReq = 1'b1;
         end
         S_ST_ADDR:  mem.memReqBus = addr_q;
         default:    mem.memReqBus = '0;
      endcase
   end

   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign ld_data     = ld_data_q;
   assign ls_done     = ls_done_q;
   assign busy        = (state_q != S_IDLE);
`ifdef MEM_BUS_ALIGN_CHECK_EN
   assign align_err   = align_err_q;
`else
   assign align_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: vector table, scoreboard, corner sequences.
// Includes a two-phase write memory model on the shared bus.
module tb_mem_bus_master;

   typedef enum int {OP_F, OP_L, OP_S} op_e;

   typedef struct {
      op_e         op;
      logic [14:0] addr;
      logic [7:0]  data;
      int          exp;
      int          lat;
      int          bus1;
      int          bus2;
      int          wr1;
   } vec_t;

   typedef struct {
      op_e op;
      int  val;
   } sb_t;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic [14:0] fetch_pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic        ld_req;
   logic        st_req;
   logic [14:0] ls_addr;
   logic [7:0]  st_data;
   logic [7:0]  ld_data;
   logic        ls_done;
   logic        align_err;
   logic        busy;

   int total = 0;
   int bad   = 0;
   sb_t sb[$];

   mem_bus_master_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus ();

   mem_bus_master #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .ld_req      (ld_req),
      .st_req      (st_req),
      .ls_addr     (ls_addr),
      .st_data     (st_data),
      .ld_data     (ld_data),
      .ls_done     (ls_done),
      .align_err   (align_err),
      .busy        (busy),
      .mem         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: data phase latches, address phase commits one edge later.
   logic [7:0] mem [0:32767];
   logic [7:0] wpend   = 8'h00;
   logic       wpend_v = 1'b0;
   assign bus.read_data = mem[bus.memReqBus];

   always @(posedge clk) begin
      if (wpend_v) begin
         mem[bus.memReqBus] <= wpend;
         wpend_v <= 1'b0;
      end
      if (bus.memWriteReq) begin
         wpend   <= bus.memReqBus[7:0];
         wpend_v <= 1'b1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every completion pulse pops one expectation.
   always @(negedge clk) begin
      if (reset && (instr_valid || ls_done)) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pulse", 1, 0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (instr_valid) begin
               chk("sb_kind_fetch", int'(e.op), int'(OP_F));
               chk("sb_instr", int'(instr), e.val);
            end
            if (ls_done) begin
               chk("sb_kind_ls", int'(e.op != OP_F), 1);
               if (e.op == OP_L) chk("sb_ld_data", int'(ld_data), e.val);
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_instr"}, int'(instr), 0);
      chk({tag, "_ld_data"}, int'(ld_data), 0);
      chk({tag, "_ivalid"}, int'(instr_valid), 0);
      chk({tag, "_ls_done"}, int'(ls_done), 0);
      chk({tag, "_align"}, int'(align_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_wr"}, int'(bus.memWriteReq), 0);
      chk({tag, "_bus"}, int'(bus.memReqBus), 0);
   endtask

   // Called at a negedge with the DUT idle; returns in the pulse cycle.
   task automatic run_vec(input vec_t v);
      int  cyc;
      bit  got;
      sb_t e;
      st_req    = (v.op == OP_S);
      ld_req    = (v.op == OP_L);
      fetch_req = (v.op == OP_F);
      fetch_pc  = v.addr;
      ls_addr   = v.addr;
      st_data   = v.data;
      e.op  = v.op;
      e.val = v.exp;
      sb.push_back(e);
      @(negedge clk);
      st_req    = 1'b0;
      ld_req    = 1'b0;
      fetch_req = 1'b0;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 8) begin
         if (cyc == 1) begin
            chk("bus_c1", int'(bus.memReqBus), v.bus1);
            chk("wr_c1", int'(bus.memWriteReq), v.wr1);
            chk("busy_c1", int'(busy), 1);
         end
         if (cyc == 2) begin
            chk("bus_c2", int'(bus.memReqBus), v.bus2);
            chk("wr_c2", int'(bus.memWriteReq), 0);
         end
         if (instr_valid || ls_done) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("latency", cyc, v.lat);
      if (got) chk("busy_done", int'(busy), 0);
   endtask

   vec_t vecs[8];
   vec_t v;

   initial begin
      reset     = 1'b0;
      fetch_req = 1'b0;
      ld_req    = 1'b0;
      st_req    = 1'b0;
      fetch_pc  = '0;
      ls_addr   = '0;
      st_data   = '0;
      for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
      mem[15'h0000] <= 8'hFF;
      mem[15'h0001] <= 8'h70;
      mem[15'h0101] <= 8'h12;
      mem[15'h0201] <= 8'hC3;
      mem[15'h7FFF] <= 8'h34;

      vecs[0] = '{OP_F, 15'h0000, 8'h00, 'h70FF, 3, 'h0000, 'h0001, 0};
      vecs[1] = '{OP_S, 15'h0100, 8'hAB, 0,      3, 'h00AB, 'h0100, 1};
      vecs[2] = '{OP_L, 15'h0100, 8'h00, 'hAB,   2, 'h0100, 'h0000, 0};
      vecs[3] = '{OP_S, 15'h0200, 8'h5A, 0,      3, 'h005A, 'h0200, 1};
      vecs[4] = '{OP_L, 15'h0200, 8'h00, 'h5A,   2, 'h0200, 'h0000, 0};
      vecs[5] = '{OP_F, 15'h0100, 8'h00, 'h12AB, 3, 'h0100, 'h0101, 0};
      vecs[6] = '{OP_L, 15'h0001, 8'h00, 'h70,   2, 'h0001, 'h0000, 0};
      vecs[7] = '{OP_F, 15'h0200, 8'h00, 'hC35A, 3, 'h0200, 'h0201, 0};

      #12;
      chk_all_zero("rst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
      @(negedge clk);

      // Store and fetch together: store wins, fetch is dropped.
      begin
         sb_t e;
         st_req    = 1'b1;
         fetch_req = 1'b1;
         ls_addr   = 15'h0300;
         st_data   = 8'h77;
         fetch_pc  = 15'h0000;
         e.op  = OP_S;
         e.val = 0;
         sb.push_back(e);
         @(negedge clk);
         st_req    = 1'b0;
         fetch_req = 1'b0;
         chk("sf_busy1", int'(busy), 1);
         chk("sf_bus1", int'(bus.memReqBus), 'h77);
         chk("sf_wr1", int'(bus.memWriteReq), 1);
         @(negedge clk);
         chk("sf_busy2", int'(busy), 1);
         chk("sf_bus2", int'(bus.memReqBus), 'h300);
         @(negedge clk);
         chk("sf_busy3", int'(busy), 0);
         chk("sf_done", int'(ls_done), 1);
         chk("sf_noinstr", int'(instr_valid), 0);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sf_idle", int'(busy), 0);
         end
      end
      v = '{OP_L, 15'h0300, 8'h00, 'h77, 2, 'h0300, 'h0000, 0};
      run_vec(v);
      @(negedge clk);

`ifndef MEM_BUS_ALIGN_CHECK_EN
      v = '{OP_F, 15'h7FFF, 8'h00, 'hFF34, 3, 'h7FFF, 'h0000, 0};
      run_vec(v);
      @(negedge clk);
`else
      fetch_req = 1'b1;
      fetch_pc  = 15'h0003;
      @(negedge clk);
      fetch_req = 1'b0;
      chk("al_err", int'(align_err), 1);
      chk("al_busy", int'(busy), 0);
      chk("al_bus", int'(bus.memReqBus), 0);
      chk("al_iv", int'(instr_valid), 0);
      @(negedge clk);
      chk("al_err_off", int'(align_err), 0);
      chk("al_busy2", int'(busy), 0);
`endif

      // Reset while in FETCH_HI: everything clears without a pulse.
      fetch_req = 1'b1;
      fetch_pc  = 15'h0000;
      @(negedge clk);
      fetch_req = 1'b0;
      @(negedge clk);
      chk("rh_in_hi", int'(bus.memReqBus), 1);
      #1 reset = 1'b0;
      #1;
      chk_all_zero("rh");
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rh_quiet", int'(instr_valid | busy), 0);
      end
      v = '{OP_F, 15'h0100, 8'h00, 'h12AB, 3, 'h0100, 'h0101, 0};
      run_vec(v);
      @(negedge clk);
      @(negedge clk);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
